// File: rtl/encoder_bcd_pkg.sv
// -----------------------------------------------------------------------------
// encoder_bcd_pkg
// Shared widths and index constants for the registered 4-to-2 encoder.
//   IN_W        : width of the one-hot request vector
//   OUT_W       : width of the encoded binary index
//   IDX0..IDX3  : binary code produced for request bit 0..3
// -----------------------------------------------------------------------------
package encoder_bcd_pkg;

    localparam int IN_W  = 4;
    localparam int OUT_W = 2;

    typedef logic [OUT_W-1:0] idx_t;

    localparam idx_t IDX0 = 2'd0;
    localparam idx_t IDX1 = 2'd1;
    localparam idx_t IDX2 = 2'd2;
    localparam idx_t IDX3 = 2'd3;

endpackage : encoder_bcd_pkg

// File: rtl/encoder_bcd_4to2_core.sv
// -----------------------------------------------------------------------------
// encoder_bcd_4to2_core
// Combinational next-state logic for the 4-to-2 encoder: priority selection of
// the winning request bit plus the "more than one bit set" check.
//   MSB_PRIORITY : 1 = highest set bit wins, 0 = lowest set bit wins
//   i            : request vector (one-hot expected, any code accepted)
//   next_o       : encoded index of the winning bit (IDX0 when i is zero)
//   next_valid   : at least one request bit set
//   next_err     : two or more request bits set
// -----------------------------------------------------------------------------
module encoder_bcd_4to2_core
    import encoder_bcd_pkg::*;
#(
    parameter bit MSB_PRIORITY = 1'b1
) (
    input  logic [IN_W-1:0]  i,
    output logic [OUT_W-1:0] next_o,
    output logic             next_valid,
    output logic             next_err
);

    logic [2:0] pop_cnt;

    always_comb begin
        next_o = IDX0;
        if (MSB_PRIORITY) begin
            if      (i[3]) next_o = IDX3;
            else if (i[2]) next_o = IDX2;
            else if (i[1]) next_o = IDX1;
            else           next_o = IDX0;
        end else begin
            if      (i[0]) next_o = IDX0;
            else if (i[1]) next_o = IDX1;
            else if (i[2]) next_o = IDX2;
            else if (i[3]) next_o = IDX3;
            else           next_o = IDX0;
        end
    end

    // Zero-extend each bit to the 3-bit count width so the sum cannot wrap.
    assign pop_cnt    = {2'b00, i[0]} + {2'b00, i[1]} + {2'b00, i[2]} + {2'b00, i[3]};
    assign next_valid = |i;
    assign next_err   = (pop_cnt > 3'd1);

endmodule : encoder_bcd_4to2_core

// File: rtl/encoder_bcd_4to2.sv
// -----------------------------------------------------------------------------
// encoder_bcd_4to2
// Registered 4-to-2 binary encoder with valid and multi-hot error flags.
// Fixed one-cycle latency from a captured request to the outputs.
//   MSB_PRIORITY : multi-hot tie-break, 1 = highest bit wins, 0 = lowest
//   clk          : rising-edge clock
//   rst_n        : synchronous active-low reset, overrides en
//   en           : capture enable; when low all outputs hold
//   i            : request vector, synchronous to clk
//   o            : registered encoded index
//   valid        : registered, captured request had at least one bit set
//   err          : registered, captured request had two or more bits set
// -----------------------------------------------------------------------------
module encoder_bcd_4to2
    import encoder_bcd_pkg::*;
#(
    parameter bit MSB_PRIORITY = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [IN_W-1:0]  i,
    output logic [OUT_W-1:0] o,
    output logic             valid,
    output logic             err
);

    logic [OUT_W-1:0] o_d;
    logic             valid_d;
    logic             err_d;

    logic [OUT_W-1:0] o_q;
    logic             valid_q;
    logic             err_q;

    encoder_bcd_4to2_core #(
        .MSB_PRIORITY (MSB_PRIORITY)
    ) u_core (
        .i          (i),
        .next_o     (o_d),
        .next_valid (valid_d),
        .next_err   (err_d)
    );

    // Output register stage: reset wins over enable, so a sample present on
    // the reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_q     <= IDX0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (en) begin
            o_q     <= o_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o     = o_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule : encoder_bcd_4to2

// File: tb/tb_encoder_bcd_4to2.sv
module tb_encoder_bcd_4to2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] i;

    logic [1:0] o_m;
    logic       valid_m;
    logic       err_m;
    logic [1:0] o_l;
    logic       valid_l;
    logic       err_l;

    int n_cmp;
    int n_bad;

    encoder_bcd_4to2 #(.MSB_PRIORITY(1'b1)) dut_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .i     (i),
        .o     (o_m),
        .valid (valid_m),
        .err   (err_m)
    );

    encoder_bcd_4to2 #(.MSB_PRIORITY(1'b0)) dut_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .i     (i),
        .o     (o_l),
        .valid (valid_l),
        .err   (err_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed/expected values are packed as {o[1:0], valid, err}.
    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {o,valid,err}=%b expected %b", tag, got, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] model(input logic [3:0] v, input bit msb);
        int       cnt;
        logic [1:0] idx;
        cnt = 0;
        idx = 2'd0;
        for (int b = 0; b < 4; b++) begin
            if (v[b]) begin
                cnt++;
                if (msb || cnt == 1) idx = 2'(b);
            end
        end
        return {idx, cnt > 0, cnt > 1};
    endfunction

    logic [3:0] onehot_in  [4];
    logic [3:0] onehot_exp [4];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        onehot_in  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        onehot_exp = '{4'b0010, 4'b0110, 4'b1010, 4'b1110};

        // Reset held two cycles with a live request on the input.
        rst_n = 1'b0;
        en    = 1'b1;
        i     = 4'b1000;
        for (int c = 0; c < 2; c++) begin
            step();
            check($sformatf("rst_msb_c%0d", c), {o_m, valid_m, err_m}, 4'b0000);
            check($sformatf("rst_lsb_c%0d", c), {o_l, valid_l, err_l}, 4'b0000);
        end
        rst_n = 1'b1;
        step();
        check("rst_rel_msb", {o_m, valid_m, err_m}, 4'b1110);
        check("rst_rel_lsb", {o_l, valid_l, err_l}, 4'b1110);

        // One-hot sweep on consecutive cycles.
        for (int k = 0; k < 4; k++) begin
            i = onehot_in[k];
            step();
            check($sformatf("onehot_msb_%b", onehot_in[k]), {o_m, valid_m, err_m}, onehot_exp[k]);
            check($sformatf("onehot_lsb_%b", onehot_in[k]), {o_l, valid_l, err_l}, onehot_exp[k]);
        end

        // Zero input.
        i = 4'b0000;
        step();
        check("zero_msb", {o_m, valid_m, err_m}, 4'b0000);
        check("zero_lsb", {o_l, valid_l, err_l}, 4'b0000);

        // Multi-hot tie-break.
        i = 4'b1010;
        step();
        check("mh1010_msb", {o_m, valid_m, err_m}, 4'b1111);
        check("mh1010_lsb", {o_l, valid_l, err_l}, 4'b0111);
        i = 4'b0111;
        step();
        check("mh0111_msb", {o_m, valid_m, err_m}, 4'b1011);
        check("mh0111_lsb", {o_l, valid_l, err_l}, 4'b0011);

        // Enable hold.
        i = 4'b0100;
        step();
        check("hold_cap_msb", {o_m, valid_m, err_m}, 4'b1010);
        en = 1'b0;
        i  = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("hold_msb_c%0d", c), {o_m, valid_m, err_m}, 4'b1010);
            check($sformatf("hold_lsb_c%0d", c), {o_l, valid_l, err_l}, 4'b1010);
        end
        en = 1'b1;
        step();
        check("hold_rel_msb", {o_m, valid_m, err_m}, 4'b0010);
        check("hold_rel_lsb", {o_l, valid_l, err_l}, 4'b0010);

        // Reset overrides a deasserted enable; the pending sample is dropped.
        i = 4'b1100;
        step();
        check("pre_rst_msb", {o_m, valid_m, err_m}, 4'b1111);
        en    = 1'b0;
        rst_n = 1'b0;
        step();
        check("rst_no_en_msb", {o_m, valid_m, err_m}, 4'b0000);
        check("rst_no_en_lsb", {o_l, valid_l, err_l}, 4'b0000);
        rst_n = 1'b1;
        en    = 1'b1;

        // Exhaustive sweep over all 16 codes for both priorities.
        for (int v = 0; v < 16; v++) begin
            i = 4'(v);
            step();
            check($sformatf("exh_msb_%0d", v), {o_m, valid_m, err_m}, model(4'(v), 1'b1));
            check($sformatf("exh_lsb_%0d", v), {o_l, valid_l, err_l}, model(4'(v), 1'b0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_encoder_bcd_4to2
